lockstep_lock_arbiter: RTL and testbench
========================================

# lockstep_lock_arbiter

Parametrised start sequencer and memory-lock arbiter for an N-core lockstep cluster. It staggers core start-up by a configurable number of cycles per core. It grants exclusive shared-memory access to one core at a time with round-robin fairness, and it holds each grant until the owner releases it or a hold-timeout expires. It sits between the core instances and the shared memory, replacing the fixed two-core, cycle-by-cycle lock logic of the existing wrapper.

## Interface
- NUM_CORES, 2: number of cores; must be ≥2.
- START_DELAY, 5: cycles between successive core starts; must be ≥1.
- MAX_HOLD, 64: maximum consecutive grant cycles per owner; must be ≥2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  level; arms the start sequencer when sampled high.
- need_lock  in  NUM_CORES  per-core shared-memory lock request.
- core_start  out  NUM_CORES  per-core start enable; sticky until reset.
- lock  out  NUM_CORES  per-core stall; 1 = core stalled.
- owner  out  OWNER_W  index of the current grant holder; valid while busy.
- busy  out  1  a grant is active.
- hold_timeout  out  1  one-cycle pulse on a forced release.
- timeout_core  out  OWNER_W  index of the last force-released core; holds its value until the next timeout.

## Operation
- Reset: core_start=0, lock=0, owner=0, busy=0, hold_timeout=0, timeout_core=0, rr_ptr=0, start counter=0, disarmed, state ARB_IDLE. A reset asserted mid-grant or mid-sequence has the same effect.
- Start sequencer:
  - The first edge with start=1 arms the sequencer, sets core_start[0] and sets cnt=1.
  - cnt increments on every later edge.
  - core_start[k] sets on the edge at which the pre-edge cnt equals k*START_DELAY.
  - The counter saturates once core_start[NUM_CORES-1] is set.
  - start=0 after arming has no effect, and start is never re-sampled.
- Arbiter FSM, states ARB_IDLE and ARB_GRANT:
  - In ARB_IDLE, lock=0 and busy=0.
  - If any need_lock bit is high, pick the first requester at or after rr_ptr (wrapping), go to ARB_GRANT, set owner, lock=~onehot(owner), busy=1 and hold_cnt=0.
- In ARB_GRANT, every non-owner core is stalled whether or not it is requesting. hold_cnt increments each cycle.
- Normal release: when need_lock[owner]=0, set rr_ptr=owner+1 mod NUM_CORES.
  - If any other bit of need_lock is high, hand off directly to the first requester after the old owner; lock updates with no idle gap.
  - Otherwise go to ARB_IDLE.
- Forced release: when hold_cnt==MAX_HOLD-1 and need_lock[owner]=1, go to ARB_IDLE, pulse hold_timeout, set timeout_core=owner and rr_ptr=owner+1.
  - The next cycle is always idle (lock=0).
  - The former owner may win again only if no other core is requesting.
- A waiting requester that drops need_lock before it is granted is forgotten; it has no queueing.
- need_lock bits of cores whose core_start=0 are ignored.

## Timing
- need_lock sampled at edge t drives lock/owner/busy after edge t; all outputs are registered.
- Handoff: owner drops need_lock at edge t; the new owner is visible after edge t.
- Grant length is ≤MAX_HOLD cycles. A forced release costs exactly one idle cycle.
- hold_timeout is high for exactly one cycle, coincident with the first idle cycle after the forced release.
- Simultaneous release and timeout (need_lock[owner]=0 at hold_cnt==MAX_HOLD-1) is treated as a normal release, with no pulse.

## Structure
- Package lockstep_pkg:
  - enum arb_state_t {ARB_IDLE, ARB_GRANT};
  - OWNER_W = $clog2(NUM_CORES), defined as a localparam or function.
- Submodule rr_arbiter_pick: combinational round-robin picker.
  - Inputs: req[NUM_CORES], ptr[OWNER_W].
  - Outputs: gnt_idx, any.
  - Instantiated twice: once for idle arbitration and once for handoff, with ptr=owner+1.
- The start sequencer and FSM stay inline in the top module.

## Test plan
- Stagger: NUM_CORES=2, START_DELAY=5, start=1 sampled at edge 0 → core_start=01 after edge 0, =11 after edge 5; pulsing start again has no effect.
- Single requester: need_lock=01 at edge t → after edge t, lock=10, owner=0, busy=1; need_lock=00 at edge t+3 → lock=00, busy=0.
- Contention/handoff: from idle with rr_ptr=0, need_lock=11 → owner=0, lock=10; core0 drops while core1 still requests → owner=1, lock=01 on the next cycle.
- Fairness: NUM_CORES=4, all requesting, each owner drops for 1 cycle after 3 grant cycles → grant order 0,1,2,3,0.
- Timeout: MAX_HOLD=8, core2 holds need_lock for 20 cycles, core3 also requesting → after 8 grant cycles, one idle cycle with hold_timeout=1, timeout_core=2, lock=0000; then owner=3.
- Reset mid-grant: rst=1 while owner=1 → after the next edge all outputs are 0, including core_start.

Source files
------------

// File: rtl/lockstep_lock_arbiter_pkg.sv
// Shared types and width helpers for the lockstep start sequencer and memory-lock arbiter.
package lockstep_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Index width for a core number; kept at least one bit wide.
  function automatic int owner_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping around.
module rr_arbiter_pick
  import lockstep_pkg::*;
#(
  parameter  int NUM_CORES = 2,
  localparam int OWNER_W   = owner_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [OWNER_W-1:0]   ptr,
  output logic [OWNER_W-1:0]   gnt_idx,
  output logic                 any
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the unassigned paths infer latches.
  always_comb begin
    int                 idx;
    logic [OWNER_W-1:0] idx_w;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      idx_w = OWNER_W'(idx);
      if (!any && req[idx_w]) begin
        any     = 1'b1;
        gnt_idx = idx_w;
      end
    end
  end

endmodule

// File: rtl/lockstep_lock_arbiter.sv
// Staggered start sequencer plus round-robin shared-memory lock arbiter with hold timeout
// for an N-core lockstep cluster.
module lockstep_lock_arbiter
  import lockstep_pkg::*;
#(
  parameter  int NUM_CORES   = 2,
  parameter  int START_DELAY = 5,
  parameter  int MAX_HOLD    = 64,
  localparam int OWNER_W     = owner_w(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] need_lock,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NUM_CORES-1:0] lock,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic                 hold_timeout,
  output logic [OWNER_W-1:0]   timeout_core
);

  localparam int CNT_W  = $clog2((NUM_CORES - 1) * START_DELAY + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD);

  // ---------------- start sequencer ----------------
  // The sequencer is armed exactly when core_start[0] is set, so no separate flag is kept.
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      core_start <= '0;
    end else if (!core_start[0]) begin
      if (start) begin
        cnt           <= CNT_W'(1);
        core_start[0] <= 1'b1;
      end
    end else if (!core_start[NUM_CORES-1]) begin
      cnt <= cnt + CNT_W'(1);
      for (int k = 1; k < NUM_CORES; k++) begin
        if (cnt == CNT_W'(k * START_DELAY)) core_start[k] <= 1'b1;
      end
    end
  end

  // ---------------- arbiter ----------------
  arb_state_t         state, state_next;
  logic [OWNER_W-1:0] owner_next, rr_ptr, rr_ptr_next, timeout_core_next, owner_inc;
  logic [NUM_CORES-1:0] lock_next, eligible;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
  logic               busy_next, hold_timeout_next;
  logic [OWNER_W-1:0] idle_idx, handoff_idx;
  logic               idle_any, handoff_any;

  // Requests from cores that have not been started yet are invisible to arbitration.
  assign eligible  = need_lock & core_start;
  assign owner_inc = (owner == OWNER_W'(NUM_CORES - 1)) ? '0 : owner + OWNER_W'(1);

  function automatic logic [NUM_CORES-1:0] stall_mask(input logic [OWNER_W-1:0] idx);
    stall_mask      = '1;
    stall_mask[idx] = 1'b0;
  endfunction

  rr_arbiter_pick #(.NUM_CORES(NUM_CORES)) u_idle_pick (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt_idx (idle_idx),
    .any     (idle_any)
  );

  rr_arbiter_pick #(.NUM_CORES(NUM_CORES)) u_handoff_pick (
    .req     (eligible),
    .ptr     (owner_inc),
    .gnt_idx (handoff_idx),
    .any     (handoff_any)
  );

  // NOTE: there is no memory array here, so every register, including the
  // round-robin pointer, is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      owner        <= '0;
      lock         <= '0;
      busy         <= 1'b0;
      hold_cnt     <= '0;
      rr_ptr       <= '0;
      hold_timeout <= 1'b0;
      timeout_core <= '0;
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      lock         <= lock_next;
      busy         <= busy_next;
      hold_cnt     <= hold_cnt_next;
      rr_ptr       <= rr_ptr_next;
      hold_timeout <= hold_timeout_next;
      timeout_core <= timeout_core_next;
    end
  end

  always_comb begin
    state_next        = state;
    owner_next        = owner;
    lock_next         = lock;
    busy_next         = busy;
    hold_cnt_next     = hold_cnt;
    rr_ptr_next       = rr_ptr;
    hold_timeout_next = 1'b0;
    timeout_core_next = timeout_core;

    case (state)
      ARB_IDLE: begin
        lock_next = '0;
        busy_next = 1'b0;
        if (idle_any) begin
          state_next    = ARB_GRANT;
          owner_next    = idle_idx;
          lock_next     = stall_mask(idle_idx);
          busy_next     = 1'b1;
          hold_cnt_next = '0;
        end
      end

      ARB_GRANT: begin
        hold_cnt_next = hold_cnt + HOLD_W'(1);
        if (!need_lock[owner]) begin
          // A release on the timeout cycle still counts as a normal release.
          rr_ptr_next = owner_inc;
          if (handoff_any) begin
            owner_next    = handoff_idx;
            lock_next     = stall_mask(handoff_idx);
            hold_cnt_next = '0;
          end else begin
            state_next = ARB_IDLE;
            lock_next  = '0;
            busy_next  = 1'b0;
          end
        end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_next        = ARB_IDLE;
          lock_next         = '0;
          busy_next         = 1'b0;
          hold_timeout_next = 1'b1;
          timeout_core_next = owner;
          rr_ptr_next       = owner_inc;
        end
      end

      default: state_next = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lockstep_lock_arbiter.sv
// Directed bench: a 2-core instance for stagger/grant/handoff/reset and a 4-core,
// short-timeout instance for fairness and hold-timeout behaviour.
module tb_lockstep_lock_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-core instance, START_DELAY=5, MAX_HOLD=64
  logic       rst_a, start_a;
  logic [1:0] need_a, core_start_a, lock_a;
  logic [0:0] owner_a, tcore_a;
  logic       busy_a, hto_a;

  // 4-core instance, START_DELAY=1, MAX_HOLD=8
  logic       rst_b, start_b;
  logic [3:0] need_b, core_start_b, lock_b;
  logic [1:0] owner_b, tcore_b;
  logic       busy_b, hto_b;

  lockstep_lock_arbiter #(.NUM_CORES(2), .START_DELAY(5), .MAX_HOLD(64)) dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .start        (start_a),
    .need_lock    (need_a),
    .core_start   (core_start_a),
    .lock         (lock_a),
    .owner        (owner_a),
    .busy         (busy_a),
    .hold_timeout (hto_a),
    .timeout_core (tcore_a)
  );

  lockstep_lock_arbiter #(.NUM_CORES(4), .START_DELAY(1), .MAX_HOLD(8)) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .start        (start_b),
    .need_lock    (need_b),
    .core_start   (core_start_b),
    .lock         (lock_b),
    .owner        (owner_b),
    .busy         (busy_b),
    .hold_timeout (hto_b),
    .timeout_core (tcore_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] sel, stall;

  initial begin
    rst_a = 1'b1; start_a = 1'b0; need_a = '0;
    rst_b = 1'b1; start_b = 1'b0; need_b = '0;
    tick(); tick();

    // ---- reset state ----
    check("rst core_start", 32'(core_start_a), 32'h0);
    check("rst lock",       32'(lock_a),       32'h0);
    check("rst busy",       32'(busy_a),       32'h0);
    check("rst owner",      32'(owner_a),      32'h0);
    check("rst timeout",    32'(hto_a),        32'h0);
    check("rst tcore",      32'(tcore_a),      32'h0);

    // ---- unstarted cores are ignored ----
    rst_a = 1'b0; need_a = 2'b11;
    tick();
    check("unstarted busy", 32'(busy_a), 32'h0);

    // ---- stagger: start at edge 0, core1 at edge 5 ----
    need_a = 2'b00; start_a = 1'b1;
    tick();
    check("stagger e0", 32'(core_start_a), 32'h1);
    start_a = 1'b0; need_a = 2'b10;
    repeat (4) tick();
    check("stagger e4",        32'(core_start_a), 32'h1);
    check("core1 not started", 32'(busy_a),       32'h0);
    need_a = 2'b00;
    tick();
    check("stagger e5", 32'(core_start_a), 32'h3);
    start_a = 1'b1; tick(); start_a = 1'b0; tick();
    check("restart ignored", 32'(core_start_a), 32'h3);

    // ---- single requester ----
    need_a = 2'b01;
    tick();
    check("single lock",  32'(lock_a),  32'h2);
    check("single owner", 32'(owner_a), 32'h0);
    check("single busy",  32'(busy_a),  32'h1);
    tick(); tick();
    check("single held", 32'(lock_a), 32'h2);
    need_a = 2'b00;
    tick();
    check("single rel lock", 32'(lock_a), 32'h0);
    check("single rel busy", 32'(busy_a), 32'h0);

    // bring rr_ptr back to 0 by granting and releasing core1
    need_a = 2'b10;
    tick();
    check("core1 owner", 32'(owner_a), 32'h1);
    check("core1 lock",  32'(lock_a),  32'h1);
    need_a = 2'b00;
    tick();
    check("core1 rel busy", 32'(busy_a), 32'h0);

    // ---- contention and handoff ----
    need_a = 2'b11;
    tick();
    check("contend owner", 32'(owner_a), 32'h0);
    check("contend lock",  32'(lock_a),  32'h2);
    need_a = 2'b10;
    tick();
    check("handoff owner", 32'(owner_a), 32'h1);
    check("handoff lock",  32'(lock_a),  32'h1);
    check("handoff busy",  32'(busy_a),  32'h1);

    // ---- reset mid-grant ----
    rst_a = 1'b1;
    tick();
    check("midrst core_start", 32'(core_start_a), 32'h0);
    check("midrst lock",       32'(lock_a),       32'h0);
    check("midrst busy",       32'(busy_a),       32'h0);
    check("midrst owner",      32'(owner_a),      32'h0);
    rst_a = 1'b0; need_a = 2'b00;

    // ---- 4-core stagger with START_DELAY=1 ----
    rst_b = 1'b0; start_b = 1'b1;
    tick();
    check("b stagger e0", 32'(core_start_b), 32'h1);
    start_b = 1'b0;
    tick(); tick();
    check("b stagger e2", 32'(core_start_b), 32'h7);
    tick();
    check("b stagger e3", 32'(core_start_b), 32'hF);

    // ---- fairness: each owner drops for one cycle after 3 grant cycles ----
    need_b = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      sel   = 4'b0001 << order[i];
      stall = ~sel;
      check($sformatf("fair owner %0d", i), 32'(owner_b), 32'(order[i]));
      check($sformatf("fair lock %0d", i),  32'(lock_b),  32'(stall));
      tick(); tick();
      need_b = stall;
      tick();
      need_b = 4'hF;
    end
    need_b = 4'h0;
    tick();
    check("fair idle", 32'(busy_b), 32'h0);

    // ---- hold timeout: core2 holds, core3 waiting (rr_ptr is 2 here) ----
    need_b = 4'b1100;
    tick();
    check("to owner",  32'(owner_b), 32'h2);
    check("to lock",   32'(lock_b),  32'hB);
    repeat (7) tick();
    check("to 8th cycle owner", 32'(owner_b), 32'h2);
    check("to 8th cycle busy",  32'(busy_b),  32'h1);
    check("to 8th cycle pulse", 32'(hto_b),   32'h0);
    tick();
    check("to idle busy",  32'(busy_b),  32'h0);
    check("to idle lock",  32'(lock_b),  32'h0);
    check("to pulse",      32'(hto_b),   32'h1);
    check("to tcore",      32'(tcore_b), 32'h2);
    tick();
    check("to next owner", 32'(owner_b), 32'h3);
    check("to next lock",  32'(lock_b),  32'h7);
    check("to pulse end",  32'(hto_b),   32'h0);
    check("to tcore held", 32'(tcore_b), 32'h2);

    // core3 releases, core2 still waiting: direct handoff
    need_b = 4'b0100;
    tick();
    check("back to core2", 32'(owner_b), 32'h2);

    // ---- release coincident with timeout is a normal release ----
    repeat (7) tick();
    check("simul pre owner", 32'(owner_b), 32'h2);
    need_b = 4'b1000;
    tick();
    check("simul no pulse", 32'(hto_b),   32'h0);
    check("simul owner",    32'(owner_b), 32'h3);
    check("simul busy",     32'(busy_b),  32'h1);
    check("simul tcore",    32'(tcore_b), 32'h2);
    need_b = 4'h0;
    tick();
    check("final idle", 32'(busy_b), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
